// File: rtl/scaler_h_ctrl.sv
// scaler_h_ctrl: frame-synchronous configuration controller for the horizontal scaler.
//
// Computes scale_step = floor(in_width * SCALE_STEP / out_width) with a restoring divider.
// The divider produces one quotient bit per cycle. The new step is handed to the scaler only
// on a rising edge of vs_i, so the scaling ratio never changes within a frame.
//
// Optional feature macro: SCALER_H_CTRL_MON_EN.
//   Defined:   an output line-length monitor is built.
//   Undefined: out_line_len and line_len_err are tied to 0.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   cfg_wr         one-cycle write strobe for cfg_in_width / cfg_out_width
//   cfg_in_width   input pixels per line
//   cfg_out_width  output pixels per line
//   cfg_busy       high while the divider runs
//   cfg_err        sticky error (zero divisor or saturated step), cleared by an accepted write
//   vs_i           input frame sync, active high
//   scale_step     step driven to the scaler
//   step_upd       one-cycle pulse when scale_step is loaded
//   mon_de_i       scaler output data enable
//   mon_hs_i       scaler output line sync, active high
//   out_line_len   last measured output line length
//   line_len_err   sticky: measured length differs from the active out_width
module scaler_h_ctrl #(
  parameter int unsigned SCALE_STEP = 4096,
  parameter int unsigned WIDTH_BITS = 13,
  parameter int unsigned STEP_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [WIDTH_BITS-1:0] cfg_in_width,
  input  logic [WIDTH_BITS-1:0] cfg_out_width,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  input  logic                  vs_i,
  output logic [STEP_WIDTH-1:0] scale_step,
  output logic                  step_upd,
  input  logic                  mon_de_i,
  input  logic                  mon_hs_i,
  output logic [WIDTH_BITS-1:0] out_line_len,
  output logic                  line_len_err
);

  localparam int unsigned FracBits = $clog2(SCALE_STEP);
  localparam int unsigned QW       = WIDTH_BITS + FracBits;
  localparam int unsigned CntW     = $clog2(QW);
  localparam logic [CntW-1:0]       LastBit = CntW'(QW - 1);
  localparam logic [STEP_WIDTH-1:0] StepOne = STEP_WIDTH'(SCALE_STEP);

  typedef enum logic [1:0] {StIdle, StDiv, StPend} state_e;

  state_e                state_q, state_d;
  logic                  vs_q;
  logic [QW-1:0]         dq_q, dq_d;     // dividend shifts out MSB-first, quotient shifts in
  logic [WIDTH_BITS:0]   rem_q, rem_d;
  logic [WIDTH_BITS-1:0] div_q, div_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [STEP_WIDTH-1:0] pend_q, pend_d;
  logic [STEP_WIDTH-1:0] step_q, step_d;
  logic                  upd_q, upd_d;
  logic                  err_q, err_d;
  logic [WIDTH_BITS-1:0] act_out_q, act_out_d;

  logic                  vs_rise;
  logic                  cfg_acc;
  logic [WIDTH_BITS:0]   rem_sh;
  logic                  rem_ge;
  logic [QW-1:0]         q_next;
  logic                  sat;

  always_comb begin
    vs_rise   = vs_i & ~vs_q;
    rem_sh    = {rem_q[WIDTH_BITS-1:0], dq_q[QW-1]};
    rem_ge    = rem_sh >= {1'b0, div_q};
    q_next    = {dq_q[QW-2:0], rem_ge};
    sat       = (q_next >> STEP_WIDTH) != '0;

    state_d   = state_q;
    dq_d      = dq_q;
    rem_d     = rem_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    step_d    = step_q;
    upd_d     = 1'b0;
    err_d     = err_q;
    act_out_d = act_out_q;
    cfg_acc   = 1'b0;

    unique case (state_q)
      StIdle, StPend: begin
        // In PEND a vs rise applies the old pending step even if a new write lands this cycle.
        if (state_q == StPend && vs_rise) begin
          step_d    = pend_q;
          upd_d     = 1'b1;
          act_out_d = div_q;
          state_d   = StIdle;
        end
        if (cfg_wr) begin
          if (cfg_out_width == '0) begin
            err_d = 1'b1;
          end else begin
            cfg_acc = 1'b1;
            div_d   = cfg_out_width;
            dq_d    = QW'(cfg_in_width) << FracBits;
            rem_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        rem_d = rem_ge ? (rem_sh - {1'b0, div_q}) : rem_sh;
        dq_d  = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          pend_d  = sat ? '1 : q_next[STEP_WIDTH-1:0];
          if (sat) err_d = 1'b1;
          state_d = StPend;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vs_q      <= 1'b0;
      dq_q      <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      pend_q    <= '0;
      step_q    <= StepOne;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      act_out_q <= '0;
    end else begin
      state_q   <= state_d;
      vs_q      <= vs_i;
      dq_q      <= dq_d;
      rem_q     <= rem_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      step_q    <= step_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      act_out_q <= act_out_d;
    end
  end

  assign cfg_busy   = (state_q == StDiv);
  assign cfg_err    = err_q;
  assign scale_step = step_q;
  assign step_upd   = upd_q;

`ifdef SCALER_H_CTRL_MON_EN
  logic [WIDTH_BITS-1:0] lcnt_q, lcnt_d;
  logic [WIDTH_BITS-1:0] len_q, len_d;
  logic                  lerr_q, lerr_d;
  logic                  hs_q;
  logic                  hs_rise;

  always_comb begin
    hs_rise = mon_hs_i & ~hs_q;
    lcnt_d  = lcnt_q;
    len_d   = len_q;
    lerr_d  = lerr_q;
    if (cfg_acc) lerr_d = 1'b0;
    if (hs_rise) begin
      // An empty line (no DE since the last sync) is not a measurement.
      if (lcnt_q != '0) begin
        len_d = lcnt_q;
        if (act_out_q != '0 && lcnt_q != act_out_q) lerr_d = 1'b1;
      end
      lcnt_d = '0;
    end else if (mon_de_i && lcnt_q != '1) begin
      lcnt_d = lcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      len_q  <= '0;
      lerr_q <= 1'b0;
      hs_q   <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      len_q  <= len_d;
      lerr_q <= lerr_d;
      hs_q   <= mon_hs_i;
    end
  end

  assign out_line_len = len_q;
  assign line_len_err = lerr_q;
`else
  logic unused_mon;
  assign unused_mon   = ^{mon_de_i, mon_hs_i, act_out_q, cfg_acc};
  assign out_line_len = '0;
  assign line_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Self-checking bench for scaler_h_ctrl. Expected steps are pushed to a queue when a vs rise is
// issued. A monitor process pops the queue and compares on every step_upd pulse.
module tb_scaler_h_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [12:0] cfg_in_width = '0;
  logic [12:0] cfg_out_width = '0;
  logic        cfg_busy;
  logic        cfg_err;
  logic        vs_i = 1'b0;
  logic [15:0] scale_step;
  logic        step_upd;
  logic        mon_de_i = 1'b0;
  logic        mon_hs_i = 1'b0;
  logic [12:0] out_line_len;
  logic        line_len_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          upd_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  scaler_h_ctrl #(
    .SCALE_STEP(4096),
    .WIDTH_BITS(13),
    .STEP_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_in_width (cfg_in_width),
    .cfg_out_width(cfg_out_width),
    .cfg_busy     (cfg_busy),
    .cfg_err      (cfg_err),
    .vs_i         (vs_i),
    .scale_step   (scale_step),
    .step_upd     (step_upd),
    .mon_de_i     (mon_de_i),
    .mon_hs_i     (mon_hs_i),
    .out_line_len (out_line_len),
    .line_len_err (line_len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: floor(in * 4096 / out) in wide arithmetic, clipped to 16 bits.
  function automatic longint raw_step(input int in_w, input int out_w);
    return (longint'(in_w) * 4096) / longint'(out_w);
  endfunction

  function automatic logic [15:0] ref_step(input int in_w, input int out_w);
    longint q;
    q = raw_step(in_w, out_w);
    if (q > 65535) return 16'hFFFF;
    return q[15:0];
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && step_upd === 1'b1) begin
      upd_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_step_upd", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("scale_step", 32'(scale_step), 32'(mon_exp));
      end
    end
  end

  task automatic wr(input int in_w, input int out_w);
    @(posedge clk); #1;
    cfg_wr        = 1'b1;
    cfg_in_width  = 13'(in_w);
    cfg_out_width = 13'(out_w);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (cfg_busy === 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check("div_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulse_vs();
    @(posedge clk); #1 vs_i = 1'b1;
    @(posedge clk); #1 vs_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("step_upd_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic apply(input int in_w, input int out_w);
    wr(in_w, out_w);
    wait_done();
    exp_q.push_back(ref_step(in_w, out_w));
    pulse_vs();
    drain();
  endtask

  task automatic mon_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 mon_de_i = 1'b1;
    end
    @(posedge clk); #1;
    mon_de_i = 1'b0;
    mon_hs_i = 1'b1;
    @(posedge clk); #1 mon_hs_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int snap;
    logic [15:0] step_snap;
    int in_w;
    int out_w;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_scale_step", 32'(scale_step), 32'd4096);
    check("rst_step_upd", 32'(step_upd), 32'd0);
    check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_out_line_len", 32'(out_line_len), 32'd0);
    check("rst_line_len_err", 32'(line_len_err), 32'd0);

    // Basic downscale with busy-length measurement
    wr(1920, 1280);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_busy === 1'b1) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd25);
    check("step_held_before_vs", 32'(scale_step), 32'd4096);
    snap = upd_cnt;
    exp_q.push_back(16'd6144);
    pulse_vs();
    drain();
    repeat (3) @(negedge clk);
    check("basic_one_pulse", 32'(upd_cnt - snap), 32'd1);
    check("basic_cfg_err", 32'(cfg_err), 32'd0);

    // Upscale; vs rise during DIV is ignored
    wr(1280, 1920);
    repeat (4) @(posedge clk);
    pulse_vs();
    @(negedge clk);
    check("vs_in_div_busy", 32'(cfg_busy), 32'd1);
    wait_done();
    check("upscale_step_held", 32'(scale_step), 32'd6144);
    exp_q.push_back(16'd2730);
    pulse_vs();
    drain();

    // Saturation, then zero divisor
    wr(8000, 100);
    wait_done();
    check("sat_cfg_err", 32'(cfg_err), 32'd1);
    exp_q.push_back(16'hFFFF);
    pulse_vs();
    drain();
    wr(10, 0);
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cfg_busy === 1'b1) busy_cnt++;
    end
    check("zero_div_busy", 32'(busy_cnt), 32'd0);
    check("zero_div_err", 32'(cfg_err), 32'd1);
    pulse_vs();
    repeat (3) @(negedge clk);
    check("zero_div_step", 32'(scale_step), 32'hFFFF);

    // Overwrite in PEND: latest configuration wins
    wr(1920, 1280);
    wait_done();
    wr(1920, 960);
    check("overwrite_err_clr", 32'(cfg_err), 32'd0);
    wait_done();
    exp_q.push_back(16'd8192);
    pulse_vs();
    drain();

    // Simultaneous vs rise and write in PEND
    wr(1920, 1280);
    wait_done();
    exp_q.push_back(16'd6144);
    @(posedge clk); #1;
    vs_i          = 1'b1;
    cfg_wr        = 1'b1;
    cfg_in_width  = 13'd1920;
    cfg_out_width = 13'd640;
    @(posedge clk); #1;
    vs_i   = 1'b0;
    cfg_wr = 1'b0;
    @(negedge clk);
    check("simul_busy", 32'(cfg_busy), 32'd1);
    drain();
    wait_done();
    exp_q.push_back(16'd12288);
    pulse_vs();
    drain();

    // Asynchronous reset mid-division
    wr(1280, 1280);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_scale_step", 32'(scale_step), 32'd4096);
    check("midrst_busy", 32'(cfg_busy), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    snap = upd_cnt;
    pulse_vs();
    repeat (5) @(negedge clk);
    check("midrst_no_upd", 32'(upd_cnt - snap), 32'd0);

    // Randomized configurations
    for (int it = 0; it < 24; it++) begin
      in_w  = int'($urandom_range(1, 8191));
      out_w = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8191));
      if (out_w == 0) begin
        step_snap = scale_step;
        wr(in_w, 0);
        @(negedge clk);
        check("rnd_zero_busy", 32'(cfg_busy), 32'd0);
        check("rnd_zero_err", 32'(cfg_err), 32'd1);
        pulse_vs();
        repeat (2) @(negedge clk);
        check("rnd_zero_step", 32'(scale_step), 32'(step_snap));
      end else begin
        apply(in_w, out_w);
        check("rnd_err", 32'(cfg_err), (raw_step(in_w, out_w) > 65535) ? 32'd1 : 32'd0);
      end
    end

    // Output line monitor
    apply(1280, 1280);
`ifdef SCALER_H_CTRL_MON_EN
    mon_line(1280);
    check("mon_len_1280", 32'(out_line_len), 32'd1280);
    check("mon_err_ok", 32'(line_len_err), 32'd0);
    mon_line(1279);
    check("mon_len_1279", 32'(out_line_len), 32'd1279);
    check("mon_err_set", 32'(line_len_err), 32'd1);
    mon_line(1280);
    check("mon_err_sticky", 32'(line_len_err), 32'd1);
    wr(1280, 1280);
    @(negedge clk);
    check("mon_err_clr", 32'(line_len_err), 32'd0);
    wait_done();
`else
    mon_line(50);
    check("mon_off_len", 32'(out_line_len), 32'd0);
    check("mon_off_err", 32'(line_len_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scaler_h_ctrl.md
# scaler_h_ctrl

Frame-synchronous configuration controller for the horizontal linear scaler. Accepts input/output line widths from a register interface and computes `scale_step = floor(in_width * SCALE_STEP / out_width)` with a multi-cycle restoring divider. Delivers the new step only on a rising edge of `vs_i`, so the scaler never changes ratio mid-frame. Optionally monitors the scaler's output stream and reports the measured output line length.

## Interface

**Parameters**
- `SCALE_STEP`, 4096: fixed-point 1.0; must be a power of two.
- `WIDTH_BITS`, 13: width of line-width fields (max 8191).
- `STEP_WIDTH`, 16: width of `scale_step`.

**Ports**
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_wr`  in  1  one-cycle write strobe for `cfg_in_width` and `cfg_out_width`.
- `cfg_in_width`  in  WIDTH_BITS  input pixels per line.
- `cfg_out_width`  in  WIDTH_BITS  output pixels per line.
- `cfg_busy`  out  1  high while the divider runs.
- `cfg_err`  out  1  sticky error flag; cleared by the next accepted `cfg_wr`.
- `vs_i`  in  1  frame sync of the input video stream; active high.
- `scale_step`  out  STEP_WIDTH  step driven to the scaler.
- `step_upd`  out  1  one-cycle pulse when `scale_step` changes.
- `mon_de_i`  in  1  scaler output data enable.
- `mon_hs_i`  in  1  scaler output line sync; active high.
- `out_line_len`  out  WIDTH_BITS  last measured output line length.
- `line_len_err`  out  1  sticky flag: measured length differs from the active `out_width`.

## Operation

- Let QW = WIDTH_BITS + log2(SCALE_STEP); QW = 25 with defaults.
- Dividend = `in_width << log2(SCALE_STEP)`, QW bits. Divisor = `out_width`.

**States**
- **IDLE**
  - `cfg_wr` with `cfg_out_width` == 0: set `cfg_err`, stay in IDLE, leave the pending value unchanged.
  - `cfg_wr` otherwise: latch both widths, clear `cfg_err`, go to DIV.
- **DIV**
  - Restoring division, one quotient bit per cycle, MSB first, for exactly QW cycles; then go to PEND.
  - `cfg_wr` in DIV is ignored. `cfg_busy` = (state == DIV).
- **PEND**
  - Holds the pending step.
  - On `vs_rise` = `vs_i & ~vs_q`: `scale_step` ← pending, pulse `step_upd`, latch active `out_width`, go to IDLE.
  - A valid `cfg_wr` in PEND restarts DIV; the latest configuration wins.
  - If `vs_rise` and `cfg_wr` occur in the same cycle, both happen: the old pending value is applied and the new division starts.

**Saturation**
- If quotient bits [QW-1:STEP_WIDTH] are nonzero: pending = all-ones and `cfg_err` is set.
- A saturated step is still applied at the next `vs_rise`.

## Timing

**Reset values**
- `scale_step` = SCALE_STEP (1:1); active `out_width` = 0.
- `step_upd`, `cfg_busy`, `cfg_err`, `out_line_len`, `line_len_err` = 0.
- State = IDLE; `vs_q` = 0.

**Latency**
- `cfg_wr` at cycle T: `cfg_busy` is high for cycles T+1 .. T+QW.
- PEND is entered at T+QW+1.
- `scale_step` and `step_upd` are registered one cycle after the `vs_rise` sample.
- `vs_rise` detected before PEND (during IDLE or DIV) has no effect.

**Reset mid-operation**
- An asynchronous reset during DIV or PEND discards the division and any pending value.
- `scale_step` returns to SCALE_STEP immediately.

**Monitor**
- Line counter increments on each `mon_de_i` cycle.
- On the rising edge of `mon_hs_i`:
  - if count ≠ 0: `out_line_len` ← count, and `line_len_err` is set if count ≠ active `out_width` while active `out_width` ≠ 0;
  - the counter then clears.
- The counter saturates at all-ones.
- `line_len_err` is cleared by an accepted `cfg_wr`.

## Configuration

- Macro `SCALER_H_CTRL_MON_EN`.
  - **Defined**: output line monitor is built as described.
  - **Undefined**: no counter logic; `out_line_len` is tied to 0, `line_len_err` is tied to 0, and `mon_de_i`/`mon_hs_i` are unused.
- Divider and FSM are identical in both builds.

## Test plan

- **Basic downscale.** Reset, then `cfg_wr` with in=1920, out=1280.
  - `cfg_busy` high for 25 cycles.
  - Pulse `vs_i`: `scale_step` = 6144, one `step_upd` pulse, `cfg_err` = 0.
- **Upscale and timing.** in=1280, out=1920 → step 2730.
  - No change to `scale_step` before `vs_rise`.
  - A `vs_rise` during DIV is ignored; the next `vs_rise` applies 2730.
- **Saturation and zero divisor.**
  - in=8000, out=100 → `scale_step` = 0xFFFF at `vs_rise`, `cfg_err` = 1.
  - Then `cfg_wr` with out=0 → `cfg_err` = 1, `cfg_busy` never rises, `scale_step` unchanged.
- **Overwrite in PEND.**
  - First write 1920/1280; in PEND, write 1920/960.
  - Next `vs_rise` gives step 8192 only.
  - Simultaneous `vs_rise` + `cfg_wr` in PEND: old value applied, `cfg_busy` rises.
- **Reset mid-operation.**
  - Drop `rst_n` during DIV at cycle 10: `scale_step` = 4096, `cfg_busy` = 0.
  - After release, `vs_rise` produces no `step_upd`.
- **Monitor (MON_EN).**
  - Active out=1280; drive 1280 `mon_de_i` cycles then an `mon_hs_i` rise → `out_line_len` = 1280, `line_len_err` = 0.
  - A line of 1279 → `line_len_err` = 1, sticky until the next `cfg_wr`.
  - Without the macro, both outputs stay 0.
